// File: rtl/mem_access_if.sv
// Bundle of the upstream (execute), data-memory and write-back signals of the memory-access stage.
// slave is the stage's view; master is the surrounding pipeline/memory view.
interface mem_access_if #(
    parameter int WORD = 64
);
    logic            in_valid;
    logic [WORD-1:0] ALUOut;
    logic [WORD-1:0] w_data;
    logic            MemRead;
    logic            MemWrite;

    logic            mem_req;
    logic            mem_we;
    logic [WORD-1:0] mem_addr;
    logic [WORD-1:0] mem_wdata;
    logic            mem_ack;
    logic [WORD-1:0] mem_rdata;

    logic            stall;
    logic            out_valid;
    logic [WORD-1:0] out_data;
    logic            misalign;
    logic            timeout_err;

    modport slave (
        input  in_valid, ALUOut, w_data, MemRead, MemWrite,
        input  mem_ack, mem_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output stall, out_valid, out_data, misalign, timeout_err
    );

    modport master (
        output in_valid, ALUOut, w_data, MemRead, MemWrite,
        output mem_ack, mem_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  stall, out_valid, out_data, misalign, timeout_err
    );
endinterface

// File: rtl/mem_access.sv
// Memory-access pipeline stage: req/ack transaction with data memory, stalls upstream while
// waiting, and hands a one-cycle registered result (load data or pass-through) to write-back.
//
// state | meaning
// IDLE  | accepting execute-stage results; pass-through and misaligned ops complete here
// REQ   | memory request outstanding; upstream stalled until ack or timeout
module mem_access #(
    parameter int WORD       = 64,
    parameter int ALIGN_BITS = 3,
    parameter int TIMEOUT    = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_access_if.slave     bus
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [WORD-1:0] addr_q, addr_d;
    logic [WORD-1:0] wdata_q, wdata_d;
    logic            out_valid_q, out_valid_d;
    logic [WORD-1:0] out_data_q, out_data_d;
    logic            misalign_q, misalign_d;
    logic            timeout_q, timeout_d;

    logic            mem_op;
    logic            aligned;

    assign mem_op  = bus.MemRead | bus.MemWrite;
    assign aligned = (bus.ALUOut[ALIGN_BITS-1:0] == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            misalign_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            misalign_q  <= misalign_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        misalign_d  = 1'b0;
        timeout_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (!mem_op) begin
                        out_valid_d = 1'b1;
                        out_data_d  = bus.ALUOut;
                    end else if (!aligned) begin
                        out_valid_d = 1'b1;
                        misalign_d  = 1'b1;
                        out_data_d  = bus.ALUOut;
                    end else begin
                        // MemWrite wins when both controls are set
                        addr_d  = bus.ALUOut;
                        wdata_d = bus.w_data;
                        we_d    = bus.MemWrite;
                        req_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (bus.mem_ack) begin
                    req_d       = 1'b0;
                    out_valid_d = 1'b1;
                    out_data_d  = we_q ? addr_q : bus.mem_rdata;
                    state_d     = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d       = 1'b0;
                    out_valid_d = 1'b1;
                    timeout_d   = 1'b1;
                    out_data_d  = addr_q;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.stall       = (state_q == REQ);
        bus.mem_req     = req_q;
        bus.mem_we      = we_q;
        bus.mem_addr    = addr_q;
        bus.mem_wdata   = wdata_q;
        bus.out_valid   = out_valid_q;
        bus.out_data    = out_data_q;
        bus.misalign    = misalign_q;
        bus.timeout_err = timeout_q;
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access stage directly downstream of the execute stage.
- Consumes the ALU result as a byte address, the second register operand as store data, and the MemRead/MemWrite controls.
- Runs a request/acknowledge transaction with the data memory, stalling the pipeline until it completes. Then presents a registered result (load data or pass-through ALU result) to write-back.
- Flags misaligned accesses and memory timeouts.

Parameters:
- WORD, 64, datapath width in bits.
- ALIGN_BITS, 3, low address bits that must be zero for an access to count as aligned (8-byte doubleword).
- TIMEOUT, 255, maximum cycles spent in REQ before the access is aborted; minimum 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  execute-stage result valid this cycle.
- ALUOut  input  WORD  ALU result: memory byte address, or pass-through result.
- w_data  input  WORD  store data.
- MemRead  input  1  load request.
- MemWrite  input  1  store request.
- mem_req  output  1  memory request, held until acknowledged.
- mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  output  WORD  latched access address.
- mem_wdata  output  WORD  latched store data.
- mem_ack  input  1  memory completion pulse; rdata is valid in the same cycle.
- mem_rdata  input  WORD  load data.
- stall  output  1  upstream must hold its inputs stable; combinational.
- out_valid  output  1  one-cycle pulse: result ready for write-back.
- out_data  output  WORD  load data or pass-through ALUOut.
- misalign  output  1  qualifies out_valid: access was not performed.
- timeout_err  output  1  qualifies out_valid: memory did not respond.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State = IDLE.
  - mem_req, mem_we, out_valid, misalign, timeout_err = 0.
  - mem_addr, mem_wdata, out_data = 0.
  - Timeout counter = 0.
  - Reset asserted during REQ drops mem_req immediately, with no out_valid.
- States: IDLE, REQ.
- stall = (state==REQ).
- out_valid, misalign and timeout_err are registered and high for exactly one cycle per completed operation.
- IDLE, in_valid=0: no action; out_valid=0 next cycle.
- IDLE, in_valid=1, MemRead=MemWrite=0: next cycle out_valid=1, out_data=ALUOut. Latency 1.
- IDLE, in_valid=1, MemRead or MemWrite, ALUOut[ALIGN_BITS-1:0] != 0: no request. Next cycle out_valid=1, misalign=1, out_data=ALUOut.
- IDLE, in_valid=1, aligned memory op:
  - Latch mem_addr=ALUOut, mem_wdata=w_data, mem_we=MemWrite.
  - mem_req=1 from the next cycle.
  - Clear the counter and go to REQ.
  - MemRead and MemWrite both set: treated as a write.
- REQ:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - in_valid and the other upstream inputs are ignored.
  - The counter increments each cycle without mem_ack.
- REQ, mem_ack=1:
  - Next cycle: mem_req=0, state=IDLE, out_valid=1.
  - Read: out_data=mem_rdata sampled in the ack cycle.
  - Write: out_data=mem_addr.
  - Minimum load/store latency is 2 cycles (request cycle plus ack cycle).
- REQ, counter reaches TIMEOUT-1 with no ack:
  - Next cycle: mem_req=0, state=IDLE, out_valid=1, timeout_err=1, out_data=mem_addr.
  - mem_ack in the same cycle as the timeout takes priority: normal completion, timeout_err=0.
- mem_ack while in IDLE: ignored, with no effect on any output.
- Back-to-back operation: a new in_valid may be accepted in the IDLE cycle that coincides with the out_valid pulse of the previous access.
- Address arithmetic: none, no wrap handling. The address is used exactly as given.

Test Plan:
- Pass-through: in_valid=1, MemRead=MemWrite=0, ALUOut=0x1234 -> next cycle out_valid=1, out_data=0x1234, mem_req never asserted, stall=0.
- Load:
  - Stimulus: ALUOut=0x40, MemRead=1; memory acks after 3 cycles with mem_rdata=0xDEADBEEF.
  - Required: mem_req=1, mem_we=0, mem_addr=0x40 until the ack; stall=1 for 4 cycles; then out_valid=1, out_data=0xDEADBEEF.
- Store:
  - Stimulus: ALUOut=0x88, w_data=0xA5A5, MemWrite=1; ack on the first REQ cycle.
  - Required: mem_we=1, mem_wdata=0xA5A5; out_valid exactly 2 cycles after acceptance; no write-data change while mem_req=1.
- Misaligned: MemRead=1, ALUOut=0x43 -> out_valid=1, misalign=1, mem_req never asserted.
- Timeout:
  - Stimulus: TIMEOUT=4, no ack -> after 4 REQ cycles, out_valid=1, timeout_err=1, mem_req=0.
  - Repeat with the ack on the final cycle -> normal completion, timeout_err=0.
- Reset mid-access: assert rst_n=0 during REQ -> mem_req falls asynchronously and no out_valid follows. After release, a new load completes normally.
